// File: rtl/attn_score_pingpong_buf_pkg.sv
// Shared sizing for the spiking-attention score buffer.
// Score words are TIME_STEPS-packed spike counts.
package attn_score_pingpong_buf_pkg;

  localparam int unsigned SYSTOLIC_UNIT_NUM = 16;
  localparam int unsigned TIME_STEPS        = 4;
  localparam int unsigned FINAL_FMAPS_WIDTH = 64;

  localparam int unsigned ATTN_DATA_W = $clog2(2 * SYSTOLIC_UNIT_NUM) * TIME_STEPS;
  localparam int unsigned ATTN_DEPTH  = FINAL_FMAPS_WIDTH * FINAL_FMAPS_WIDTH;
  localparam int unsigned ATTN_ADDR_W = $clog2(ATTN_DEPTH);
  localparam int unsigned ATTN_BANKS  = 2;

endpackage

// File: rtl/attn_score_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (BRAM-inferable).
module attn_score_sdp_ram #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/attn_score_pingpong_buf.sv
// Two-bank ping-pong store for attention score maps: the producer fills one
// bank in raster order while the consumer reads the other by address.
module attn_score_pingpong_buf
  import attn_score_pingpong_buf_pkg::*;
#(
  parameter int unsigned DATA_W = ATTN_DATA_W,
  parameter int unsigned DEPTH  = ATTN_DEPTH,
  parameter int unsigned ADDR_W = ATTN_ADDR_W
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic              i_attn_valid,
  input  logic [DATA_W-1:0] i_attn_data,
  output logic              o_attn_ready,
  input  logic [ADDR_W-1:0] i_AttnRam_rd_addr,
  input  logic              i_AttnRam_Done,
  output logic              o_AttnRAM_Empty,
  output logic [DATA_W-1:0] o_AttnRAM_data,
  output logic              o_err_done_empty
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [ATTN_BANKS-1:0] full_q, full_d;
  logic                  wr_sel_q, wr_sel_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic                  err_q, err_d;
  logic                  rd_bank_q;
  logic                  rd_vld_q;
  logic                  accept;
  logic [DATA_W-1:0]     bank_rd_data [ATTN_BANKS];

  assign o_attn_ready     = !full_q[wr_sel_q];
  assign o_AttnRAM_Empty  = !full_q[rd_sel_q];
  assign o_err_done_empty = err_q;
  assign accept           = i_attn_valid && o_attn_ready;

  // Writer and reader always sit on different banks whenever both update,
  // so the last-write and Done updates never target the same flag.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    if (accept) begin
      if (wr_cnt_q == LastAddr) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = !wr_sel_q;
        wr_cnt_d         = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    if (i_AttnRam_Done) begin
      if (full_q[rd_sel_q]) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = !rd_sel_q;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      full_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      wr_cnt_q  <= wr_cnt_d;
      err_q     <= err_d;
      rd_bank_q <= rd_sel_q;
      rd_vld_q  <= 1'b1;
    end
  end

  for (genvar b = 0; b < ATTN_BANKS; b++) begin : g_bank
    attn_score_sdp_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk     (s_clk),
      .wr_en   (accept && (wr_sel_q == 1'(b))),
      .wr_addr (wr_cnt_q),
      .wr_data (i_attn_data),
      .rd_addr (i_AttnRam_rd_addr),
      .rd_data (bank_rd_data[b])
    );
  end

  // Bank select is the one in force when the read was issued; output is zero until
  // the first read after reset completes.
  assign o_AttnRAM_data = rd_vld_q ? bank_rd_data[rd_bank_q] : '0;

endmodule

// File: tb/tb_attn_score_pingpong_buf.sv
// Directed bench for attn_score_pingpong_buf: vector table plus multi-cycle sequences.
module tb_attn_score_pingpong_buf;

  localparam int DW    = 20;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          s_clk = 1'b0;
  logic          s_rst_n = 1'b0;
  logic          attn_valid = 1'b0;
  logic [DW-1:0] attn_data = '0;
  logic          attn_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          done = 1'b0;
  logic          empty;
  logic [DW-1:0] rd_data;
  logic          err;

  int n_run  = 0;
  int n_fail = 0;

  always #5 s_clk = ~s_clk;

  attn_score_pingpong_buf dut (
    .s_clk             (s_clk),
    .s_rst_n           (s_rst_n),
    .i_attn_valid      (attn_valid),
    .i_attn_data       (attn_data),
    .o_attn_ready      (attn_ready),
    .i_AttnRam_rd_addr (rd_addr),
    .i_AttnRam_Done    (done),
    .o_AttnRAM_Empty   (empty),
    .o_AttnRAM_data    (rd_data),
    .o_err_done_empty  (err)
  );

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          done;
    logic          exp_ready;
    logic          exp_empty;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge s_clk);
    #1;
  endtask

  task automatic do_reset();
    s_rst_n    = 1'b0;
    attn_valid = 1'b0;
    done       = 1'b0;
    repeat (2) @(posedge s_clk);
    @(negedge s_clk);
    s_rst_n = 1'b1;
  endtask

  task automatic write_words(input int n, input bit inv, input bit chk_last);
    int            stalls;
    logic [DW-1:0] w;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      w          = DW'(i);
      attn_valid = 1'b1;
      attn_data  = inv ? ~w : w;
      if (!attn_ready) stalls++;
      if (chk_last && i == n - 1) check("empty_before_last", 32'(empty), 32'd1);
      step();
    end
    attn_valid = 1'b0;
    check("wr_no_stall", 32'(stalls), 32'd0);
    if (chk_last) check("empty_after_last", 32'(empty), 32'd0);
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      attn_valid = vecs[i].valid;
      attn_data  = vecs[i].data;
      rd_addr    = vecs[i].addr;
      done       = vecs[i].done;
      step();
      check($sformatf("vec%0d_ready", i), 32'(attn_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
    end
    attn_valid = 1'b0;
    done       = 1'b0;
  endtask

  initial begin
    // Single-frame readback: data == addr.
    vecs[0]  = '{1'b0, 20'h0,     12'd0,    1'b0, 1'b1, 1'b0, 20'h00000};
    vecs[1]  = '{1'b0, 20'h0,     12'd1,    1'b0, 1'b1, 1'b0, 20'h00001};
    vecs[2]  = '{1'b0, 20'h0,     12'd2047, 1'b0, 1'b1, 1'b0, 20'h007FF};
    vecs[3]  = '{1'b0, 20'h0,     12'd4095, 1'b0, 1'b1, 1'b0, 20'h00FFF};
    // Both banks full: third frame held off, then Done releases bank A.
    vecs[4]  = '{1'b1, 20'h12345, 12'd0,    1'b0, 1'b0, 1'b0, 20'h00000};
    vecs[5]  = '{1'b1, 20'h12345, 12'd1,    1'b0, 1'b0, 1'b0, 20'h00001};
    vecs[6]  = '{1'b1, 20'h12345, 12'd4095, 1'b1, 1'b1, 1'b0, 20'h00FFF};
    vecs[7]  = '{1'b1, 20'h12345, 12'd5,    1'b0, 1'b1, 1'b0, 20'hFFFFA};
    vecs[8]  = '{1'b0, 20'h0,     12'd0,    1'b0, 1'b1, 1'b0, 20'hFFFFF};
    // Last write of B coincides with Done on A.
    vecs[9]  = '{1'b1, 20'hFF000, 12'd4095, 1'b1, 1'b1, 1'b0, 20'h00FFF};
    vecs[10] = '{1'b0, 20'h0,     12'd4095, 1'b0, 1'b1, 1'b0, 20'hFF000};
    vecs[11] = '{1'b0, 20'h0,     12'd5,    1'b0, 1'b1, 1'b0, 20'hFFFFA};

    // 1: reset / idle
    do_reset();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ready", 32'(attn_ready), 32'd1);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // 2: single frame
    write_words(DEPTH, 1'b0, 1'b1);
    apply_vecs(0, 3);

    // 3: ping-pong
    write_words(DEPTH, 1'b1, 1'b0);
    check("pp_ready_both_full", 32'(attn_ready), 32'd0);
    apply_vecs(4, 8);
    check("pp_err", 32'(err), 32'd0);

    // 4: collision
    do_reset();
    write_words(DEPTH, 1'b0, 1'b0);
    write_words(DEPTH - 1, 1'b1, 1'b0);
    check("col_ready_pre", 32'(attn_ready), 32'd1);
    check("col_empty_pre", 32'(empty), 32'd0);
    apply_vecs(9, 11);
    check("col_err", 32'(err), 32'd0);

    // 5: Done while empty
    do_reset();
    done = 1'b1;
    step();
    done = 1'b0;
    check("de_err", 32'(err), 32'd1);
    check("de_empty", 32'(empty), 32'd1);
    check("de_ready", 32'(attn_ready), 32'd1);
    repeat (3) step();
    check("de_err_sticky", 32'(err), 32'd1);
    write_words(DEPTH, 1'b0, 1'b1);
    rd_addr = 12'd7;
    step();
    check("de_read7", 32'(rd_data), 32'h7);
    check("de_err_after_frame", 32'(err), 32'd1);

    // 6: reset mid-frame
    do_reset();
    write_words(1000, 1'b1, 1'b0);
    #2;
    s_rst_n = 1'b0;
    #1;
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_ready", 32'(attn_ready), 32'd1);
    check("mid_rst_data", 32'(rd_data), 32'd0);
    do_reset();
    check("mid_rst_err", 32'(err), 32'd0);
    write_words(DEPTH, 1'b0, 1'b1);
    rd_addr = 12'd0;
    step();
    check("mid_rst_read0", 32'(rd_data), 32'h0);
    rd_addr = 12'd999;
    step();
    check("mid_rst_read999", 32'(rd_data), 32'h3E7);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
